divider: RTL
============

# divider

Multi-cycle signed 32-bit divider for the execute stage, the counterpart of the single-cycle multiplier. It serves the `div` and `mod` instructions. The block accepts one operation per start pulse and computes it by restoring shift-subtract at one quotient bit per cycle. It returns either the quotient or the remainder with a fixed latency. The pipeline stalls on `busy` and captures `result` on `done`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `start` input 1: request pulse; accepted only in IDLE.
- `A` input 32: dividend, two's complement; sampled on the accepting edge.
- `B` input 32: divisor, two's complement; sampled on the accepting edge.
- `isMod` input 1: 0 = return quotient, 1 = return remainder; sampled on the accepting edge.
- `result` output 32: quotient or remainder; updated only on the `done` edge, held until the next `done` or reset.
- `busy` output 1: high while an operation is in flight (RUN and FIX).
- `done` output 1: one-cycle pulse, `result` valid in the same cycle.
- `div_by_zero` output 1: registered with `result`; high when the divisor of the finished operation was 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: if `start` is high, register the following and go to RUN with the iteration counter at 0:
  - |A| and |B| as 32-bit unsigned values (|0x80000000| = 0x80000000);
  - sign_q = A[31]^B[31];
  - sign_r = A[31];
  - the `isMod` value;
  - the B==0 condition.
- IDLE: otherwise stay in IDLE.
- RUN: restoring step per cycle:
  - rem = {rem[31:0], dvd[31]}, a 33-bit working remainder;
  - dvd shifted left 1;
  - if rem ≥ |B|: rem -= |B|, quotient bit = 1; else quotient bit = 0;
  - counter increments; after the step with counter = 31, go to FIX.
- FIX: apply signs and select the output:
  - Q = sign_q ? -q : q; R = sign_r ? -r : r (truncation toward zero, remainder takes dividend sign);
  - `result` = isMod ? R : Q;
  - divisor-zero override: Q = 0xFFFFFFFF, R = A (original signed dividend), `div_by_zero` = 1;
  - assert `done` and go to IDLE.
- Overflow 0x80000000 / 0xFFFFFFFF: Q = 0x80000000, R = 0; no flag.
- `start` in RUN or FIX is ignored, with no queueing and no operand capture.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset (`rst_n` low at an edge): state = IDLE, `result` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, counter = 0. This applies in any state and aborts an in-flight operation with no `done`.
- Start accepted at edge N:
  - `busy` is 1 after edges N through N+32 and falls after edge N+33;
  - `done` is 1 for exactly the cycle after edge N+33;
  - latency is fixed at 33 cycles, independent of operand values, including divide-by-zero.
- Back-to-back: `start` high in the `done` cycle (state IDLE) is accepted at edge N+34. This gives 34-cycle throughput.
- `done` never asserts without a preceding accepted `start`.
- `result` and `div_by_zero` change only on `done` edges or reset.

## Test plan
- 100 / 7: isMod=0 → `result` 0x0000000E; isMod=1 → 0x00000002; `done` exactly 33 edges after the accepting edge, `busy` high 33 cycles.
- Sign combinations, with isMod=0 / isMod=1:
  - -100/7 → Q 0xFFFFFFF2, R 0xFFFFFFFE;
  - 100/-7 → Q 0xFFFFFFF2, R 0x00000002;
  - -100/-7 → Q 0x0000000E, R 0xFFFFFFFE.
- Divide by zero: A=5, B=0 → Q 0xFFFFFFFF, R 0x00000005, `div_by_zero`=1. Same latency. The next normal op clears the flag.
- Overflow and edge values:
  - 0x80000000 / 0xFFFFFFFF → Q 0x80000000, R 0;
  - 0 / 35 → 0;
  - 0x7FFFFFFF / 1 → 0x7FFFFFFF.
- Handshake:
  - a second `start` with different operands mid-RUN is ignored, and the first result is returned;
  - `start` held high in the `done` cycle starts the next op immediately.
- Reset mid-operation: `rst_n` low at edge N+10 → all outputs 0 next cycle, no `done`. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/divider.sv
// divider
//   Multi-cycle signed 32-bit divider (div / mod) for the execute stage.
//   Restoring shift-subtract, one quotient bit per cycle. Fixed latency of
//   33 cycles from the accepting edge to the done pulse, including the
//   divide-by-zero case.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request pulse, accepted only while idle
//   A, B         signed dividend / divisor, sampled on the accepting edge
//   isMod        0 = return quotient, 1 = return remainder
//   result       quotient or remainder, updated only on the done edge
//   busy         high while an operation is in flight
//   done         one-cycle pulse, result valid in the same cycle
//   div_by_zero  registered with result; set when the divisor was 0
module divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        isMod,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;       // working remainder (always < |B| between steps)
  logic [31:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
  logic [31:0] divs_q, divs_d;     // |B|
  logic        sgnq_q, sgnq_d;
  logic        sgnr_q, sgnr_d;
  logic        mod_q, mod_d;
  logic        bz_q, bz_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        rem_ge;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_signed;
  logic [31:0] r_signed;

  // Magnitudes; |0x80000000| wraps to 0x80000000, which is correct as unsigned.
  always_comb begin
    abs_a = A[31] ? -A : A;
    abs_b = B[31] ? -B : B;
  end

  // One restoring step.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    rem_sub   = rem_shift - {1'b0, divs_q};
    rem_ge    = (rem_shift >= {1'b0, divs_q});
  end

  // Sign fix-up. With a zero divisor every step subtracts nothing, so the
  // final remainder is |A| and the signed remainder already equals A; only
  // the quotient needs the override.
  always_comb begin
    q_signed = sgnq_q ? -dvd_q : dvd_q;
    r_signed = sgnr_q ? -rem_q : rem_q;
    if (bz_q) begin
      q_signed = '1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    divs_d   = divs_q;
    sgnq_d   = sgnq_q;
    sgnr_d   = sgnr_q;
    mod_d    = mod_q;
    bz_d     = bz_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = '0;
          dvd_d   = abs_a;
          divs_d  = abs_b;
          sgnq_d  = A[31] ^ B[31];
          sgnr_d  = A[31];
          mod_d   = isMod;
          bz_d    = (B == '0);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rem_ge) begin
          rem_d = rem_sub[31:0];
        end else begin
          rem_d = rem_shift[31:0];
        end
        dvd_d = {dvd_q[30:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = mod_q ? r_signed : q_signed;
        dbz_d    = bz_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      divs_q   <= '0;
      sgnq_q   <= 1'b0;
      sgnr_q   <= 1'b0;
      mod_q    <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      divs_q   <= divs_d;
      sgnq_q   <= sgnq_d;
      sgnr_q   <= sgnr_d;
      mod_q    <= mod_d;
      bz_q     <= bz_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);

endmodule
